// File: rtl/csa_adder_pipe_if.sv
// csa_adder_pipe_if: operand/result handshake bundle
// for the pipelined carry-select adder.
interface csa_adder_pipe_if #(
  parameter int WIDTH = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/csa_adder_pipe.sv
// csa_adder_pipe: pipelined carry-select add/sub.
// CSA_SUB_EN enables per-operation subtraction.
module csa_adder_pipe #(
  parameter int WIDTH  = 28,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  csa_adder_pipe_if.slave io
);
  localparam int NB = WIDTH / BLK;

  typedef logic [BLK:0] blk_t;

  function automatic blk_t badd(
    input logic [BLK-1:0] x,
    input logic [BLK-1:0] y,
    input logic           c
  );
    return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, c};
  endfunction

  logic en;
  assign en = !io.out_valid || io.out_ready;
  assign io.in_ready = en;

  logic [WIDTH-1:0] a_q, bb_q, bb_d;
  logic             c0_q, c0_d, v0_q;

`ifdef CSA_SUB_EN
  assign bb_d = io.sub ? ~io.b : io.b;
  assign c0_d = io.sub | io.cin;
`else
  logic unused_sub;
  assign unused_sub = io.sub;
  assign bb_d = io.b;
  assign c0_d = io.cin;
`endif

  // rank 0: effective operands and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      bb_q <= '0;
      c0_q <= 1'b0;
      v0_q <= 1'b0;
    end else if (en) begin
      a_q  <= io.a;
      bb_q <= bb_d;
      c0_q <= c0_d;
      v0_q <= io.in_valid;
    end
  end

  // segment inputs: index 0 is rank 0, others are ranks
  logic [WIDTH-1:0] v_s0 [0:STAGES-1];
  logic [WIDTH-1:0] v_s1 [0:STAGES-1];
  logic [NB-1:0]    v_k0 [0:STAGES-1];
  logic [NB-1:0]    v_k1 [0:STAGES-1];
  logic             v_m0 [0:STAGES-1];
  logic             v_m1 [0:STAGES-1];
  logic             v_c  [0:STAGES-1];
  logic             v_v  [0:STAGES-1];

  logic [WIDTH-1:0] q_s0 [1:STAGES];
  logic [WIDTH-1:0] q_s1 [1:STAGES];
  logic [NB-1:0]    q_k0 [1:STAGES];
  logic [NB-1:0]    q_k1 [1:STAGES];
  logic             q_m0 [1:STAGES];
  logic             q_m1 [1:STAGES];
  logic             q_c  [1:STAGES];
  logic             q_v  [1:STAGES];

  logic [WIDTH-1:0] n_s0 [1:STAGES];
  logic [WIDTH-1:0] n_s1 [1:STAGES];
  logic [NB-1:0]    n_k0 [1:STAGES];
  logic [NB-1:0]    n_k1 [1:STAGES];
  logic             n_m0 [1:STAGES];
  logic             n_m1 [1:STAGES];
  logic             n_c  [1:STAGES];
  logic             n_v  [1:STAGES];
  logic             n_ovf, ovf_q;

  blk_t r0, r1;
  logic c, ci;

  // dual-rail block adds from rank 0, plus rank views
  always_comb begin
    v_s0[0] = '0;
    v_s1[0] = '0;
    v_k0[0] = '0;
    v_k1[0] = '0;
    r0 = '0;
    r1 = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0) begin
        r0 = badd(a_q[0 +: BLK], bb_q[0 +: BLK], c0_q);
        r1 = r0;
      end else begin
        r0 = badd(a_q[k*BLK +: BLK], bb_q[k*BLK +: BLK], 1'b0);
        r1 = badd(a_q[k*BLK +: BLK], bb_q[k*BLK +: BLK], 1'b1);
      end
      v_s0[0][k*BLK +: BLK] = r0[BLK-1:0];
      v_s1[0][k*BLK +: BLK] = r1[BLK-1:0];
      v_k0[0][k] = r0[BLK];
      v_k1[0][k] = r1[BLK];
    end
    // carry into the MSB, recovered from its sum bit
    v_m0[0] = v_s0[0][WIDTH-1] ^ a_q[WIDTH-1] ^ bb_q[WIDTH-1];
    v_m1[0] = v_s1[0][WIDTH-1] ^ a_q[WIDTH-1] ^ bb_q[WIDTH-1];
    v_c[0]  = c0_q;
    v_v[0]  = v0_q;
    for (int s = 1; s < STAGES; s++) begin
      v_s0[s] = q_s0[s];
      v_s1[s] = q_s1[s];
      v_k0[s] = q_k0[s];
      v_k1[s] = q_k1[s];
      v_m0[s] = q_m0[s];
      v_m1[s] = q_m1[s];
      v_c[s]  = q_c[s];
      v_v[s]  = q_v[s];
    end
  end

  // each segment resolves its own blocks by carry select
  always_comb begin
    n_ovf = 1'b0;
    c  = 1'b0;
    ci = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      n_s0[s+1] = v_s0[s];
      n_s1[s+1] = v_s1[s];
      n_k0[s+1] = v_k0[s];
      n_k1[s+1] = v_k1[s];
      n_m0[s+1] = v_m0[s];
      n_m1[s+1] = v_m1[s];
      c = v_c[s];
      for (int k = 0; k < NB; k++) begin
        if ((k * STAGES) / NB == s) begin
          ci = c;
          n_s0[s+1][k*BLK +: BLK] = c ? v_s1[s][k*BLK +: BLK]
                                      : v_s0[s][k*BLK +: BLK];
          n_s1[s+1][k*BLK +: BLK] = n_s0[s+1][k*BLK +: BLK];
          c = c ? v_k1[s][k] : v_k0[s][k];
          if (k == NB - 1)
            n_ovf = (ci ? v_m1[s] : v_m0[s]) ^ c;
        end
      end
      n_c[s+1] = c;
      n_v[s+1] = v_v[s];
    end
  end

  // segment ranks advance together with rank 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= STAGES; s++) begin
        q_s0[s] <= '0;
        q_s1[s] <= '0;
        q_k0[s] <= '0;
        q_k1[s] <= '0;
        q_m0[s] <= 1'b0;
        q_m1[s] <= 1'b0;
        q_c[s]  <= 1'b0;
        q_v[s]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int s = 1; s <= STAGES; s++) begin
        q_s0[s] <= n_s0[s];
        q_s1[s] <= n_s1[s];
        q_k0[s] <= n_k0[s];
        q_k1[s] <= n_k1[s];
        q_m0[s] <= n_m0[s];
        q_m1[s] <= n_m1[s];
        q_c[s]  <= n_c[s];
        q_v[s]  <= n_v[s];
      end
      ovf_q <= n_ovf;
    end
  end

  // last rank only needs resolved sum and carry
  logic unused_rails;
  assign unused_rails = ^{q_s1[STAGES], q_k0[STAGES],
                          q_k1[STAGES], q_m0[STAGES],
                          q_m1[STAGES]};

  assign io.sum       = {q_c[STAGES], q_s0[STAGES]};
  assign io.ovf       = ovf_q;
  assign io.out_valid = q_v[STAGES];
endmodule

// File: tb/tb_csa_adder_pipe.sv
// tb_csa_adder_pipe: directed and random checks
// of csa_adder_pipe in three configurations.
module tb_csa_adder_pipe;
`ifdef CSA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ra [3];
  logic [31:0] rb [3];
  logic        rcin [3];
  logic        rsub [3];
  logic        riv [3];
  logic        ror [3];
  logic        rir [3];
  logic        rov [3];
  logic [32:0] rsum [3];
  logic        rovf [3];

  int n_cmp = 0;
  int n_bad = 0;
  int lat [3];
  int wid [3];

  logic [32:0] es [3][1024];
  logic        eo [3][1024];
  int          ea [3][1024];
  int          hd [3];
  int          tl [3];

  csa_adder_pipe_if #(.WIDTH(28)) io0 ();
  csa_adder_pipe_if #(.WIDTH(32)) io4 ();
  csa_adder_pipe_if #(.WIDTH(32)) io1 ();

  assign io0.in_valid  = riv[0];
  assign io0.a         = ra[0][27:0];
  assign io0.b         = rb[0][27:0];
  assign io0.cin       = rcin[0];
  assign io0.sub       = rsub[0];
  assign io0.out_ready = ror[0];
  assign rir[0]  = io0.in_ready;
  assign rov[0]  = io0.out_valid;
  assign rsum[0] = {4'b0, io0.sum};
  assign rovf[0] = io0.ovf;

  assign io4.in_valid  = riv[1];
  assign io4.a         = ra[1];
  assign io4.b         = rb[1];
  assign io4.cin       = rcin[1];
  assign io4.sub       = rsub[1];
  assign io4.out_ready = ror[1];
  assign rir[1]  = io4.in_ready;
  assign rov[1]  = io4.out_valid;
  assign rsum[1] = io4.sum;
  assign rovf[1] = io4.ovf;

  assign io1.in_valid  = riv[2];
  assign io1.a         = ra[2];
  assign io1.b         = rb[2];
  assign io1.cin       = rcin[2];
  assign io1.sub       = rsub[2];
  assign io1.out_ready = ror[2];
  assign rir[2]  = io1.in_ready;
  assign rov[2]  = io1.out_valid;
  assign rsum[2] = io1.sum;
  assign rovf[2] = io1.ovf;

  csa_adder_pipe #(.WIDTH(28), .BLK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .io(io0)
  );
  csa_adder_pipe #(.WIDTH(32), .BLK(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .io(io4)
  );
  csa_adder_pipe #(.WIDTH(32), .BLK(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .io(io1)
  );

  // arithmetic reference: {carry, a+b+cin} or {no-borrow, a-b}
  function automatic void model(
    input  int          w,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic [32:0] s,
    output logic        o
  );
    longint m, ai, bi, sa, sb, r, full, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ai = longint'(a) & m;
    bi = longint'(b) & m;
    if (sub && SUB_EN)
      full = ((ai - bi) & m) | ((ai >= bi) ? (m + 1) : 0);
    else
      full = ai + bi + longint'(cin);
    s  = full[32:0];
    sa = (ai >= half) ? ai - (m + 1) : ai;
    sb = (bi >= half) ? bi - (m + 1) : bi;
    r  = (sub && SUB_EN) ? sa - sb : sa + sb + longint'(cin);
    o  = (r > half - 1) || (r < -half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(
    input logic        v,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        c,
    input logic        s
  );
    riv[0]  = v;
    ra[0]   = a;
    rb[0]   = b;
    rcin[0] = c;
    rsub[0] = s;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    ror[0] = 1'b0;
    tick();
    tick();
    got = {io0.in_ready, io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h", got, 32'h8000_0000);
    end
    n_cmp++;
    if ({rov[1], rov[2]} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_sweep_valid got %b want 00",
               {rov[1], rov[2]});
    end
    rst = 1'b0;
    ror[0] = 1'b1;
  endtask

  task automatic test_carry_ripple();
    logic [30:0] got;
    drive0(1'b1, 32'hFFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (io0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ripple_early got %b want 0", io0.out_valid);
    end
    tick();
    got = {io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== {2'b10, 29'h1000_0000}) begin
      n_bad++;
      $display("FAIL ripple_sum got %h want %h",
               got, {2'b10, 29'h1000_0000});
    end
    tick();
    n_cmp++;
    if (io0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ripple_after got %b want 0", io0.out_valid);
    end
  endtask

  task automatic test_ovf_sub();
    logic [30:0] got, want;
    drive0(1'b1, 32'h7FF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    drive0(1'b1, 32'h5, 32'h7, 1'b0, 1'b1);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    got = {io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== {2'b11, 29'h0800_0000}) begin
      n_bad++;
      $display("FAIL ovf_add got %h want %h",
               got, {2'b11, 29'h0800_0000});
    end
    tick();
    want = SUB_EN ? {2'b10, 29'h0FFF_FFFE} : {2'b10, 29'hC};
    got = {io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL sub_5_7 got %h want %h", got, want);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] got;
    drive0(1'b1, 32'd1, 32'd1, 1'b1, 1'b0);
    tick();
    drive0(1'b1, 32'd2, 32'd2, 1'b1, 1'b0);
    tick();
    drive0(1'b1, 32'd3, 32'd3, 1'b1, 1'b0);
    tick();
    drive0(1'b1, 32'd4, 32'd4, 1'b1, 1'b0);
    ror[0] = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      got = {io0.in_ready, io0.out_valid, io0.ovf, io0.sum};
      n_cmp++;
      if (got !== {3'b010, 29'd3}) begin
        n_bad++;
        $display("FAIL stall_%0d got %h want %h",
                 j, got, {3'b010, 29'd3});
      end
    end
    ror[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      riv[0] = 1'b0;
      got = {1'b0, io0.out_valid, io0.ovf, io0.sum};
      n_cmp++;
      if (got !== {3'b010, 29'(5 + 2 * j)}) begin
        n_bad++;
        $display("FAIL drain_%0d got %h want %h",
                 j, got, {3'b010, 29'(5 + 2 * j)});
      end
    end
    tick();
    n_cmp++;
    if (io0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_end got %b want 0", io0.out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] a1, b1, a2, b2;
    logic        c1, c2, s1, s2, o1, o2;
    logic [32:0] e1, e2;
    logic [30:0] got;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom;
    c1 = 1'($urandom_range(0, 1));
    c2 = 1'($urandom_range(0, 1));
    s1 = 1'($urandom_range(0, 1));
    s2 = 1'($urandom_range(0, 1));
    model(28, a1, b1, c1, s1, e1, o1);
    model(28, a2, b2, c2, s2, e2, o2);
    drive0(1'b1, a1, b1, c1, s1);
    tick();
    drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive0(1'b1, a2, b2, c2, s2);
    tick();
    riv[0] = 1'b0;
    got = {io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== {1'b1, o1, e1[28:0]}) begin
      n_bad++;
      $display("FAIL bubble_a got %h want %h",
               got, {1'b1, o1, e1[28:0]});
    end
    tick();
    n_cmp++;
    if (io0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bubble_gap got %b want 0", io0.out_valid);
    end
    tick();
    got = {io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== {1'b1, o2, e2[28:0]}) begin
      n_bad++;
      $display("FAIL bubble_b got %h want %h",
               got, {1'b1, o2, e2[28:0]});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    drive0(1'b1, 32'h0ABC_DEF1, 32'h0123_4567, 1'b1, 1'b0);
    tick();
    drive0(1'b1, 32'h0FFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
    tick();
    riv[0] = 1'b0;
    rst = 1'b1;
    #1;
    got = {io0.in_ready, io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL rst_mid got %h want %h", got, 32'h8000_0000);
    end
    tick();
    tick();
    rst = 1'b0;
    drive0(1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      tick();
      riv[0] = 1'b0;
      n_cmp++;
      if (io0.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_stale_%0d got %b want 0",
                 j, io0.out_valid);
      end
    end
    tick();
    got = {1'b0, io0.out_valid, io0.ovf, io0.sum};
    n_cmp++;
    if (got !== {3'b010, 29'd3}) begin
      n_bad++;
      $display("FAIL rst_new got %h want %h",
               got, {3'b010, 29'd3});
    end
    tick();
  endtask

  task automatic test_random(input int ncyc);
    logic [32:0] s;
    logic        o;
    int          h;
    for (int cyc = 0; cyc < ncyc + 20; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (cyc < ncyc) begin
          riv[d]  = ($urandom_range(0, 9) < 7);
          ror[d]  = ($urandom_range(0, 9) < 7);
          ra[d]   = $urandom;
          rb[d]   = $urandom;
          rcin[d] = 1'($urandom_range(0, 1));
          rsub[d] = 1'($urandom_range(0, 1));
        end else begin
          riv[d] = 1'b0;
          ror[d] = 1'b1;
        end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        if (rov[d]) begin
          n_cmp++;
          h = hd[d] % 1024;
          if (hd[d] == tl[d]) begin
            n_bad++;
            $display("FAIL rand_d%0d spurious sum=%h", d, rsum[d]);
          end else if (rsum[d] !== es[d][h] ||
                       rovf[d] !== eo[d][h] ||
                       ea[d][h] != lat[d]) begin
            n_bad++;
            $display("FAIL rand_d%0d got %h/%b/%0d want %h/%b/%0d",
                     d, rsum[d], rovf[d], ea[d][h],
                     es[d][h], eo[d][h], lat[d]);
          end
        end
        if (rir[d]) begin
          if (rov[d] && ror[d] && hd[d] != tl[d]) hd[d]++;
          for (int i = hd[d]; i < tl[d]; i++)
            ea[d][i % 1024]++;
          if (riv[d]) begin
            model(wid[d], ra[d], rb[d], rcin[d], rsub[d], s, o);
            es[d][tl[d] % 1024] = s;
            eo[d][tl[d] % 1024] = o;
            ea[d][tl[d] % 1024] = 0;
            tl[d]++;
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (hd[d] != tl[d]) begin
        n_bad++;
        $display("FAIL rand_d%0d_lost got %0d want 0",
                 d, tl[d] - hd[d]);
      end
    end
  endtask

  initial begin
    lat[0] = 2; lat[1] = 4; lat[2] = 1;
    wid[0] = 28; wid[1] = 32; wid[2] = 32;
    for (int d = 0; d < 3; d++) begin
      ra[d] = '0; rb[d] = '0;
      rcin[d] = 1'b0; rsub[d] = 1'b0;
      riv[d] = 1'b0; ror[d] = 1'b1;
      hd[d] = 0; tl[d] = 0;
    end
    test_reset();
    test_carry_ripple();
    test_ovf_sub();
    test_back_pressure();
    test_bubbles();
    test_reset_mid();
    test_random(4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
